// File: rtl/rvbranch_pred.sv
// rvbranch_pred: dynamic branch predictor and redirect controller.
//
// A direct-mapped BTB with a 2-bit saturating counter per entry is looked up
// combinationally in Fetch. Branches and jumps are resolved in Execute
// against the branch unit's decision. On a misprediction the corrected PC is
// produced and the Decode/Execute registers are flushed.
//
// Optional feature macro: BPRED_STATS_EN
//   defined     : BranchCount / MispredCount are 32-bit saturating counters
//   not defined : no counter flops; both outputs are tied to 0
//
// Ports
//   clk, reset         clock, asynchronous active-high reset
//   PCF                Fetch PC for lookup
//   PredTakenF         BTB hit and counter MSB set
//   PredTargetF        predicted target (0 when not predicted taken)
//   ValidE, StallE     Execute holds a real instruction / is stalled
//   BranchE, JumpE     Execute instruction is a conditional branch / jump
//   RVPCSrcE           actual taken decision from the branch unit
//   PredTakenE         Fetch prediction carried to Execute
//   PredTargetE        Fetch predicted target carried to Execute
//   PCE                Execute PC (BTB update index/tag)
//   PCTargetE          computed branch/jump target
//   PCPlus4E           fall-through PC
//   MispredictE        redirect required this cycle
//   RedirectPCE        corrected next PC (0 unless MispredictE)
//   FlushD, FlushE     clear Decode / Execute registers at next edge
//   BranchCount        resolved branch/jump count
//   MispredCount       misprediction count
module rvbranch_pred #(
  parameter int XLEN     = 32,
  parameter int IDX_BITS = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] PCF,
  output logic            PredTakenF,
  output logic [XLEN-1:0] PredTargetF,
  input  logic            ValidE,
  input  logic            StallE,
  input  logic            BranchE,
  input  logic            JumpE,
  input  logic            RVPCSrcE,
  input  logic            PredTakenE,
  input  logic [XLEN-1:0] PredTargetE,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] PCTargetE,
  input  logic [XLEN-1:0] PCPlus4E,
  output logic            MispredictE,
  output logic [XLEN-1:0] RedirectPCE,
  output logic            FlushD,
  output logic            FlushE,
  output logic [31:0]     BranchCount,
  output logic [31:0]     MispredCount
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_W   = XLEN - IDX_BITS - 2;

  logic              valid_q [ENTRIES];
  logic [TAG_W-1:0]  tag_q   [ENTRIES];
  logic [1:0]        ctr_q   [ENTRIES];
  logic [XLEN-1:0]   tgt_q   [ENTRIES];

  logic [IDX_BITS-1:0] idx_f, idx_e;
  logic [TAG_W-1:0]    tag_f, tag_e;
  logic                hit_f, hit_e;
  logic                resolve_e, taken_e;

  // Instructions are word aligned; the low PC bits carry no BTB information.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{PCF[1:0], PCE[1:0]};

  // Fetch lookup (reads current flop contents, so a same-cycle update to the
  // same index is not seen until the following cycle).
  assign idx_f       = PCF[IDX_BITS+1:2];
  assign tag_f       = PCF[XLEN-1:IDX_BITS+2];
  assign hit_f       = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
  assign PredTakenF  = hit_f && ctr_q[idx_f][1];
  assign PredTargetF = PredTakenF ? tgt_q[idx_f] : '0;

  // Execute resolve
  assign idx_e     = PCE[IDX_BITS+1:2];
  assign tag_e     = PCE[XLEN-1:IDX_BITS+2];
  assign hit_e     = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
  assign resolve_e = ValidE && !StallE && (BranchE || JumpE);
  assign taken_e   = RVPCSrcE;

  // Direction wrong, or both taken but toward a stale target.
  assign MispredictE = resolve_e &&
                       ((taken_e != PredTakenE) ||
                        (taken_e && PredTakenE && (PredTargetE != PCTargetE)));
  assign RedirectPCE = MispredictE ? (taken_e ? PCTargetE : PCPlus4E) : '0;
  assign FlushD      = MispredictE;
  assign FlushE      = MispredictE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        ctr_q[i]   <= 2'b01;
        tgt_q[i]   <= '0;
      end
    end else if (resolve_e) begin
      if (hit_e) begin
        if (taken_e) begin
          if (ctr_q[idx_e] != 2'b11) ctr_q[idx_e] <= ctr_q[idx_e] + 2'd1;
          tgt_q[idx_e] <= PCTargetE;
        end else if (ctr_q[idx_e] != 2'b00) begin
          ctr_q[idx_e] <= ctr_q[idx_e] - 2'd1;
        end
      end else if (taken_e) begin
        // Allocation evicts whatever occupied this index. Jumps start
        // strongly taken since they always redirect.
        valid_q[idx_e] <= 1'b1;
        tag_q[idx_e]   <= tag_e;
        tgt_q[idx_e]   <= PCTargetE;
        ctr_q[idx_e]   <= JumpE ? 2'b11 : 2'b10;
      end
    end
  end

`ifdef BPRED_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      BranchCount  <= '0;
      MispredCount <= '0;
    end else begin
      if (resolve_e && (BranchCount != 32'hFFFF_FFFF))
        BranchCount <= BranchCount + 32'd1;
      if (MispredictE && (MispredCount != 32'hFFFF_FFFF))
        MispredCount <= MispredCount + 32'd1;
    end
  end
`else
  assign BranchCount  = '0;
  assign MispredCount = '0;
`endif

endmodule

// File: doc/rvbranch_pred.md
# rvbranch_pred

Dynamic branch predictor and redirect controller for the RISC-V pipeline. It holds a direct-mapped BTB with a 2-bit saturating counter per entry, looked up in Fetch. It resolves predictions in Execute against the branch unit's taken decision (RVPCSrcE). On a misprediction it issues the corrected PC and flushes the Decode and Execute pipeline registers.

## Interface
- XLEN, 32, address/data width
- IDX_BITS, 4, BTB index width (2^IDX_BITS entries)
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- PCF  in  XLEN  Fetch PC
- PredTakenF  out  1  Fetch prediction: BTB hit and counter[1]
- PredTargetF  out  XLEN  predicted target; 0 when PredTakenF=0
- ValidE  in  1  Execute holds a real instruction (0 = bubble)
- StallE  in  1  Execute stage stalled
- BranchE, JumpE  in  1  Execute instruction is a conditional branch / jump
- RVPCSrcE  in  1  actual taken decision from the branch unit
- PredTakenE  in  1  PredTakenF carried down the pipeline
- PredTargetE  in  XLEN  PredTargetF carried down the pipeline
- PCE, PCTargetE, PCPlus4E  in  XLEN  Execute PC, computed target, PC+4
- MispredictE  out  1  redirect required this cycle
- RedirectPCE  out  XLEN  corrected next PC
- FlushD, FlushE  out  1  clear Decode / Execute registers at the next edge
- BranchCount, MispredCount  out  32  statistics (see Configuration)

## Operation
- Index = PC[IDX_BITS+1:2]. Tag = PC[XLEN-1:IDX_BITS+2]. Entry = {valid, tag, ctr[1:0], target[XLEN-1:0]}.
- Lookup (Fetch) is combinational. hit = valid & tag match. PredTakenF = hit & ctr[1]. PredTargetF = PredTakenF ? target : 0.
- Resolve: resolveE = ValidE & ~StallE & (BranchE | JumpE). ActualTaken = RVPCSrcE.
- MispredictE = resolveE & ((ActualTaken != PredTakenE) | (ActualTaken & PredTakenE & PredTargetE != PCTargetE)).
- RedirectPCE = ActualTaken ? PCTargetE : PCPlus4E. It is valid only while MispredictE=1; otherwise it is 0.
- FlushD = FlushE = MispredictE.
- Update happens at the clock edge when resolveE=1, using PCE's index and tag.
  - Hit: ctr increments if taken and decrements if not, saturating at 00/11. target ← PCTargetE if taken.
  - Miss, taken: allocate with valid=1, tag, target=PCTargetE, ctr=10 for a branch or 11 for a jump. This replaces the previous occupant.
  - Miss, not taken: no change.
- Jumps count as always taken. A jump reaching Execute with PredTakenE=0 mispredicts.
- A non-branch instruction never updates the BTB and never mispredicts, even if PredTakenE=1. Correcting that case is the decoder's job.

## Timing
- Lookup latency is 0 cycles. An update becomes visible to lookup on the cycle after the edge that writes it.
- Update and lookup on the same index in the same cycle: the lookup returns the pre-update entry (read-before-write).
- Misprediction penalty is 2 cycles: the F and D instructions are squashed, and the redirect fetch happens on the next edge.
- StallE=1 suppresses MispredictE, flushes and updates. The resolve happens on the first unstalled cycle.
- Reset, asynchronous, even mid-resolve:
  - all valid bits ← 0, all ctr ← 01, targets ← 0
  - PredTakenF=0, PredTargetF=0, MispredictE=0 (given ValidE=0 during reset), RedirectPCE=0, FlushD=FlushE=0
  - counters ← 0
  - No partial update survives.
- Counters saturate at 0xFFFFFFFF.

## Configuration
- BPRED_STATS_EN defined:
  - BranchCount increments on every resolveE.
  - MispredCount increments on every MispredictE.
  - Both are 32-bit, saturating, and cleared by reset.
- Not defined: no counter flops are built; BranchCount and MispredCount are tied to 0. Ports are present in both builds.

## Test plan
- Reset, then PCF=0x100 → PredTakenF=0, PredTargetF=0. Every cycle after reset: outputs 0 while ValidE=0.
- Branch PCE=0x100, target 0x140, RVPCSrcE=1, PredTakenE=0 → MispredictE=1, RedirectPCE=0x140, FlushD=FlushE=1. Next cycle PCF=0x100 → PredTakenF=1, PredTargetF=0x140.
- Same branch resolved not-taken three times with correct PredTakenE each time → ctr goes 10→01→00→00 (saturated). Lookup gives PredTakenF=0. The first resolve (PredTakenE=1, actual 0) gives MispredictE=1, RedirectPCE=0x104.
- Jump at 0x200, target 0x300, predicted taken with PredTargetE=0x2F0 → MispredictE=1, RedirectPCE=0x300. Entry target updated to 0x300.
- Mispredicting resolve with StallE=1 → no flush, no update. StallE drops → MispredictE=1 for exactly one cycle. Reset asserted during a resolve cycle → BTB empty afterward.
- With BPRED_STATS_EN: 5 resolves, 2 mispredicts → BranchCount=5, MispredCount=2. Without the macro: both read 0.
